// File: rtl/led_fade_if.sv
// Pin-side bundle of the LED fade driver: flow-stage targets in, PWM drive and busy out.
interface led_fade_if;
  logic [1:0] led_in;
  logic [1:0] pwm_out;
  logic       busy;

  modport master (output led_in, input pwm_out, input busy);
  modport slave  (input led_in, output pwm_out, output busy);
endinterface

// File: rtl/led_fade_driver.sv
// Two-channel LED fader: each on/off target becomes a linear brightness ramp on a shared PWM.
// Optional LED_FADE_GAMMA_EN maps level to a squared duty for a perceptually linear fade.
//
// state | meaning
// OFF   | level 0, waiting for target on
// RISE  | level climbs one LSB per step_tick
// ON    | level MAX, waiting for target off
// FALL  | level drops one LSB per step_tick
module led_fade_driver #(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 4
) (
  input logic       clk,
  input logic       rst,
  led_fade_if.slave bus
);
  localparam logic [PWM_W-1:0] MAX       = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] ONE       = PWM_W'(1);
  localparam int               SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_OFF, S_RISE, S_ON, S_FALL} state_t;

  logic [PWM_W-1:0] pwm_cnt;
  logic [SW-1:0]    step_cnt;
  logic             period_end;
  logic             step_tick;
  state_t           state [2];
  logic [PWM_W-1:0] level [2];
  logic [PWM_W-1:0] duty  [2];
  logic [1:0]       pwm_q;

  assign period_end = (pwm_cnt == MAX - ONE);
  assign step_tick  = period_end && (step_cnt == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + ONE;
      if (period_end)
        step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_W-1:0] sq [2];
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sq[i]   = {{PWM_W{1'b0}}, level[i]} * ({{PWM_W{1'b0}}, level[i]} + (2*PWM_W)'(1));
      duty[i] = sq[i][2*PWM_W-1:PWM_W];
    end
  end
`else
  assign duty[0] = level[0];
  assign duty[1] = level[1];
`endif

  // A direction change takes priority over a coinciding step_tick, so reversals never jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= S_OFF;
        level[i] <= '0;
      end
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pwm_q[i] <= (pwm_cnt < duty[i]);
        case (state[i])
          S_OFF: if (bus.led_in[i]) state[i] <= S_RISE;
          S_RISE: begin
            if (!bus.led_in[i]) state[i] <= S_FALL;
            else if (step_tick) begin
              level[i] <= level[i] + ONE;
              if (level[i] == MAX - ONE) state[i] <= S_ON;
            end
          end
          S_ON: if (!bus.led_in[i]) state[i] <= S_FALL;
          S_FALL: begin
            if (bus.led_in[i]) state[i] <= S_RISE;
            else if (step_tick) begin
              level[i] <= level[i] - ONE;
              if (level[i] == ONE) state[i] <= S_OFF;
            end
          end
          default: state[i] <= S_OFF;
        endcase
      end
    end
  end

  assign bus.pwm_out = pwm_q;
  assign bus.busy    = (state[0] == S_RISE) || (state[0] == S_FALL) ||
                       (state[1] == S_RISE) || (state[1] == S_FALL);
endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver (PWM_W=4, STEP_DIV=2): compares per-period PWM patterns.
module tb_led_fade_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_fade_if bus ();
  led_fade_driver #(.PWM_W(4), .STEP_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [14:0] p0;
    logic [14:0] p1;
    logic [14:0] bz;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   edge_n = 0;

  task automatic chk(string tag, logic [14:0] obs, logic [14:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] duty_mask(int lvl);
    int d;
`ifdef LED_FADE_GAMMA_EN
    d = (lvl * (lvl + 1)) >> 4;
`else
    d = lvl;
`endif
    return 15'((1 << d) - 1);
  endfunction

  // Window p covers edges 15p+1 .. 15p+15 after reset release; busy holds for edges < busy_end.
  task automatic push(string name, int p, int lvl0, int lvl1, int busy_end);
    exp_t e;
    e.p0 = duty_mask(lvl0);
    e.p1 = duty_mask(lvl1);
    for (int k = 0; k < 15; k++) e.bz[k] = ((15 * p + k + 1) < busy_end);
    e.tag = $sformatf("%s_w%0d", name, p);
    sb.push_back(e);
  endtask

  task automatic reset_dut(logic [1:0] val);
    @(negedge clk);
    rst = 1'b1;
    bus.led_in = 2'b00;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 15'({bus.pwm_out, bus.busy}), 15'd0);
    rst = 1'b0;
    bus.led_in = val;
    edge_n = 0;
  endtask

  // Runs n windows, popping one expectation per window; optionally changes led_in after sample ck of window cw.
  task automatic run_windows(int n, int cw, int ck, logic [1:0] cv);
    logic [14:0] p0, p1, bz;
    exp_t e;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 15; k++) begin
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        p0[k] = bus.pwm_out[0];
        p1[k] = bus.pwm_out[1];
        bz[k] = bus.busy;
        if (w == cw && k == ck) bus.led_in = cv;
      end
      if (sb.size() == 0) begin
        chk("sb_underflow", 15'd1, 15'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_ch0"}, p0, e.p0);
        chk({e.tag, "_ch1"}, p1, e.p1);
        chk({e.tag, "_busy"}, bz, e.bz);
      end
    end
  endtask

  initial begin
    bus.led_in = 2'b00;

    // Idle after reset: outputs stay quiet.
    reset_dut(2'b00);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle", 15'({bus.pwm_out, bus.busy}), 15'd0);
    end

    // Fade in channel 0 up to ON and hold at full duty.
    reset_dut(2'b01);
    for (int p = 0; p < 32; p++) push("fade_in", p, (p / 2 > 15) ? 15 : p / 2, 0, 450);
    run_windows(32, -1, 0, 2'b00);

    // Reverse at level 5: fall resumes from 5 with no jump.
    reset_dut(2'b01);
    for (int p = 0; p < 21; p++) push("reverse", p, (p < 10) ? p / 2 : 10 - p / 2, 0, 300);
    run_windows(21, 9, 14, 2'b00);

    // Reverse on a step_tick edge at level 3: level holds instead of stepping to 4.
    reset_dut(2'b01);
    for (int p = 0; p < 15; p++) push("tick_rev", p, (p < 8) ? p / 2 : 7 - p / 2, 0, 210);
    run_windows(15, 7, 13, 2'b00);

    // Reset mid-ramp on channel 1 at level 7.
    reset_dut(2'b10);
    for (int p = 0; p < 15; p++) push("ch1_ramp", p, 0, p / 2, 100000);
    run_windows(15, -1, 0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    chk("pre_async_rst", 15'({bus.pwm_out, bus.busy}), 15'b101);
    #1 rst = 1'b1;
    #1 chk("async_rst", 15'({bus.pwm_out, bus.busy}), 15'd0);

    // Both channels restart from level 0 after release.
    reset_dut(2'b11);
    for (int p = 0; p < 32; p++) push("restart", p, (p / 2 > 15) ? 15 : p / 2, (p / 2 > 15) ? 15 : p / 2, 450);
    run_windows(32, -1, 0, 2'b00);

    chk("sb_empty", 15'(sb.size()), 15'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
